// File: rtl/key_debounce_pkg.sv
// Shared state encodings and sizing helper for key_debounce and hold_timer.
package key_debounce_pkg;
    `include "key_debounce_defs.vh"

    // Counter width for a terminal value, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        int unsigned w;
        w = $clog2(max_val);
        return (w == 0) ? 1 : w;
    endfunction
endpackage

// File: rtl/hold_timer.sv
// Saturating hold counter with a one-shot registered strobe when it reaches LIMIT-1.
module hold_timer
    import key_debounce_pkg::*;
#(
    parameter int unsigned LIMIT = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int unsigned W = cnt_width(LIMIT + 1);
    localparam logic [W-1:0] CNT_FIRE = W'(LIMIT - 1);
    localparam logic [W-1:0] CNT_SAT  = W'(LIMIT);

    logic [W-1:0] cnt_q;

    // Counting one past the fire point and stopping there keeps the strobe one-shot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
            end else if (enable && (cnt_q != CNT_SAT)) begin
                cnt_q <= cnt_q + 1'b1;
                tick  <= (cnt_q == CNT_FIRE);
            end
        end
    end
endmodule

// File: rtl/key_debounce_defs.vh
// State encodings for the key_debounce filter FSM, shared through key_debounce_pkg.
`ifndef KEY_DEBOUNCE_DEFS_VH
`define KEY_DEBOUNCE_DEFS_VH
localparam logic [1:0] S_IDLE       = 2'd0;
localparam logic [1:0] S_PRESS_FILT = 2'd1;
localparam logic [1:0] S_PRESSED    = 2'd2;
localparam logic [1:0] S_REL_FILT   = 2'd3;
`endif

// File: rtl/key_debounce.sv
// Push-button debouncer: clean level, press/release strobes, optional long-press strobe.
// Long press is built only when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned CNT_MAX    = 1_000_000,
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter int unsigned LONG_MAX   = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);
    localparam int unsigned CW = cnt_width(CNT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic          pressed;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_d, press_d, release_d;

    assign pressed = ACTIVE_LOW ? ~key_in : key_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pressed) begin
                    state_d = S_PRESS_FILT;
                    cnt_d   = '0;
                end
            end
            S_PRESS_FILT: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PRESSED: begin
                if (!pressed) begin
                    state_d = S_REL_FILT;
                    cnt_d   = '0;
                end
            end
            S_REL_FILT: begin
                if (pressed) begin
                    state_d = S_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_press   <= press_d;
            key_release <= release_d;
        end
    end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    // Hold time accumulates only in PRESSED, pauses through release bounces, resets in IDLE.
    hold_timer #(
        .LIMIT(LONG_MAX)
    ) u_hold_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == S_IDLE),
        .enable(state_q == S_PRESSED),
        .tick  (key_long)
    );
`else
    // LONG_MAX has no effect in this build; the AND keeps the output a constant 0.
    assign key_long = 1'b0 & (|LONG_MAX);
`endif
endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce (CNT_MAX=8, LONG_MAX=32, ACTIVE_LOW=1).
module tb_key_debounce;
    logic clk = 1'b0;
    logic rst;
    logic key_in;
    logic key_level, key_press, key_release, key_long;

    int checks   = 0;
    int failures = 0;

    key_debounce #(
        .CNT_MAX   (8),
        .ACTIVE_LOW(1'b1),
        .LONG_MAX  (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk = ~clk;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs n cycles with key_in held, tallying strobes and the cycle (1-based) they last fired.
    int pc, pi, rc, ri, lc, li;
    task automatic run(input int n, input logic lvl);
        pc = 0; pi = 0; rc = 0; ri = 0; lc = 0; li = 0;
        key_in = lvl;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (key_press)   begin pc++; pi = i; end
            if (key_release) begin rc++; ri = i; end
            if (key_long)    begin lc++; li = i; end
        end
    endtask

    initial begin
        int outs;
        int seen;
        // 1. reset with key held low, then 9 low samples needed
        rst = 1'b1;
        key_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            outs = {28'd0, key_level, key_press, key_release, key_long};
            check("reset_outputs", outs, 0);
        end
        rst = 1'b0;
        seen = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            seen += int'(key_level) + int'(key_press) + int'(key_release) + int'(key_long);
        end
        check("post_reset_quiet_8", seen, 0);
        tick();
        check("first_press_9th", int'(key_press), 1);
        check("first_level_9th", int'(key_level), 1);
        tick();
        check("press_one_cycle", int'(key_press), 0);
        check("level_held", int'(key_level), 1);

        run(12, 1'b1);
        check("rel1_count", rc, 1);
        check("rel1_index", ri, 9);
        check("rel1_level", int'(key_level), 0);

        // 2. clean press held 20 cycles
        run(20, 1'b0);
        check("t2_press_count", pc, 1);
        check("t2_press_index", pi, 9);
        check("t2_level", int'(key_level), 1);
        check("t2_no_long", lc, 0);
        run(12, 1'b1);
        check("t2_rel_count", rc, 1);

        // toggling every cycle never qualifies
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            key_in = ~key_in;
            tick();
            seen += int'(key_press) + int'(key_release);
        end
        check("toggle_no_strobe", seen, 0);
        run(3, 1'b1);

        // 3. low 5, high 1, low 12
        run(5, 1'b0);
        seen = pc;
        run(1, 1'b1);
        seen += pc;
        check("t3_bounce_no_press", seen, 0);
        run(12, 1'b0);
        check("t3_press_count", pc, 1);
        check("t3_press_index", pi, 9);

        // 4. short release bounce while pressed
        run(3, 1'b1);
        check("t4_bounce_no_release", rc, 0);
        check("t4_level_during", int'(key_level), 1);
        run(10, 1'b0);
        check("t4_no_release_after", rc, 0);
        check("t4_level_after", int'(key_level), 1);
        check("t4_no_long", lc, 0);
        run(12, 1'b1);
        check("t4_final_release", rc, 1);
        check("t4_release_index", ri, 9);

        // 5. reset mid-filter
        run(5, 1'b0);
        check("t5_pre_reset_no_press", pc, 0);
        rst = 1'b1;
        #1;
        check("t5_async_level", int'(key_level), 0);
        tick();
        outs = {28'd0, key_level, key_press, key_release, key_long};
        check("t5_reset_outputs", outs, 0);
        rst = 1'b0;
        run(8, 1'b0);
        check("t5_no_press_8", pc, 0);
        run(1, 1'b0);
        check("t5_press_9th", pc, 1);
        run(12, 1'b1);
        check("t5_release", rc, 1);

        // 6. long hold
        run(60, 1'b0);
        check("t6_press_index", pi, 9);
        check("t6_long_count", lc, LONG_ON ? 1 : 0);
        check("t6_long_index", li, LONG_ON ? 41 : 0);
        run(12, 1'b1);
        check("t6_release_count", rc, 1);
        check("t6_release_index", ri, 9);
        check("t6_no_long_on_release", lc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
